// File: rtl/bus_reg_loader.sv
// Register file loader for a shared datapath bus: one-hot write select, malformed-write
// detection with a saturating error count, and a one-cycle decode stall after an IR load.
// Optional feature macro: LOADER_R7_AUTOINC_EN (R7 increments on pc_incr).
module bus_reg_loader #(
  parameter int WIDTH = 16
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic [WIDTH-1:0] BusWires,
  input  logic [12:0]      load,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic             pc_incr,
  output logic [WIDTH-1:0] R0,
  output logic [WIDTH-1:0] R1,
  output logic [WIDTH-1:0] R2,
  output logic [WIDTH-1:0] R3,
  output logic [WIDTH-1:0] R4,
  output logic [WIDTH-1:0] R5,
  output logic [WIDTH-1:0] R6,
  output logic [WIDTH-1:0] R7,
  output logic [WIDTH-1:0] G,
  output logic [WIDTH-1:0] H,
  output logic [WIDTH-1:0] I,
  output logic [WIDTH-1:0] J,
  output logic [WIDTH-1:0] IR,
  output logic             load_err,
  output logic [7:0]       err_count
);

  localparam int N_REGS = 13;
  localparam int IR_IDX = 12;
  localparam int R7_IDX = 7;

  typedef enum logic {
    IDLE  = 1'b0,
    STALL = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_regs [N_REGS];
  logic             r_load_err;
  logic [7:0]       r_err_count;

  logic w_accept;
  logic w_onehot;
  logic w_write;
  logic w_bad;

  assign wr_ready = (r_state == IDLE);
  assign w_accept = wr_valid && wr_ready;
  assign w_onehot = $onehot(load);
  assign w_write  = w_accept && w_onehot;
  assign w_bad    = w_accept && !w_onehot;

  always_comb begin
    // NOTE: next state defaults to the current state first, so no path through the
    // case statement leaves it unassigned and no latch is inferred.
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_write && load[IR_IDX]) w_state_next = STALL;
      STALL:   w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) r_state <= IDLE;
    else         r_state <= w_state_next;
  end

  // NOTE: the register file is deliberately reset because its cleared contents are
  // architecturally visible; it is flop-based, not a RAM macro.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      for (int k = 0; k < N_REGS; k++) r_regs[k] <= '0;
    end else begin
      for (int k = 0; k < N_REGS; k++) begin
        if (w_write && load[k]) r_regs[k] <= BusWires;
      end
`ifdef LOADER_R7_AUTOINC_EN
      // A same-edge write to R7 takes priority over the increment.
      if (pc_incr && !(w_write && load[R7_IDX])) r_regs[R7_IDX] <= r_regs[R7_IDX] + WIDTH'(1);
`endif
    end
  end

`ifndef LOADER_R7_AUTOINC_EN
  logic w_unused_pc_incr;
  assign w_unused_pc_incr = pc_incr;
`endif

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_load_err  <= 1'b0;
      r_err_count <= 8'd0;
    end else begin
      r_load_err <= w_bad;
      if (w_bad && (r_err_count != 8'hFF)) r_err_count <= r_err_count + 8'd1;
    end
  end

  assign R0        = r_regs[0];
  assign R1        = r_regs[1];
  assign R2        = r_regs[2];
  assign R3        = r_regs[3];
  assign R4        = r_regs[4];
  assign R5        = r_regs[5];
  assign R6        = r_regs[6];
  assign R7        = r_regs[R7_IDX];
  assign G         = r_regs[8];
  assign H         = r_regs[9];
  assign I         = r_regs[10];
  assign J         = r_regs[11];
  assign IR        = r_regs[IR_IDX];
  assign load_err  = r_load_err;
  assign err_count = r_err_count;

endmodule

// File: doc/bus_reg_loader.md
BUS_REG_LOADER -- requirements
Module: bus_reg_loader

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the bus and register width.
REQ-002 Clock: input, 1 bit, sole clock, rising edge.
REQ-003 Resetn: input, 1 bit, reset, asynchronous, active-low.
REQ-004 BusWires: input, WIDTH bits, shared datapath bus value to be written.
REQ-005 load: input, 13 bits, one-hot write select. Bits 0-7 are R0in..R7in, bit 8 is Gin, bit 9 is Hin, bit 10 is Iin, bit 11 is Jin, bit 12 is IRin.
REQ-006 wr_valid: input, 1 bit, the write request is present this cycle.
REQ-007 wr_ready: output, 1 bit, the block can accept a write this cycle.
REQ-008 pc_incr: input, 1 bit, R7 increment request; used only when LOADER_R7_AUTOINC_EN is defined.
REQ-009 R0..R7, G, H, I, J, IR: outputs, WIDTH bits each, registered register contents.
REQ-010 load_err: output, 1 bit, one-cycle pulse flagging a rejected, malformed write.
REQ-011 err_count: output, 8 bits, saturating count of malformed writes.

Function
REQ-012 A write SHALL be accepted on a rising edge where wr_valid=1 and wr_ready=1.
REQ-013 An accepted write with exactly one load bit set SHALL copy BusWires into the selected register at that edge, visible on the next cycle (latency 1).
REQ-014 An accepted write with load=0 or with two or more bits set SHALL update no register.
REQ-015 Such a malformed write SHALL drive load_err=1 for exactly the following cycle and SHALL increment err_count by 1.
REQ-016 err_count SHALL saturate at 255 and SHALL NOT wrap.
REQ-017 wr_valid=0 SHALL leave every register, load_err=0 and err_count unchanged, whatever the value of load.
REQ-018 The state machine SHALL have two states, IDLE and STALL; wr_ready=1 in IDLE and 0 in STALL.
REQ-019 In IDLE, an accepted well-formed write with load=bit 12 (IR) SHALL move the machine to STALL; every other case stays in IDLE.
REQ-020 STALL SHALL last exactly one cycle and then return to IDLE unconditionally (decode bubble).
REQ-021 In STALL, wr_valid SHALL be ignored: no register update, no error, no count change.
REQ-022 Registers not selected by an accepted write SHALL hold their value.

Reset
REQ-023 Resetn=0 SHALL immediately force all thirteen registers to 0, err_count=0, load_err=0 and the state to IDLE, independent of Clock.
REQ-024 Reset asserted while in STALL SHALL abort the stall, and wr_ready SHALL read 1 while reset is held.
REQ-025 The first write SHALL be accepted on the first rising edge with Resetn=1.

Configuration
REQ-026 The single compile option SHALL be the macro LOADER_R7_AUTOINC_EN.
REQ-027 With LOADER_R7_AUTOINC_EN defined, R7 SHALL increment by 1 modulo 2^WIDTH on each edge with pc_incr=1 (0xFFFF becomes 0x0000), including edges in STALL.
REQ-028 When a well-formed accepted write selects R7 on the same edge as pc_incr=1, the write SHALL win and the increment SHALL be discarded.
REQ-029 Without LOADER_R7_AUTOINC_EN, the pc_incr port SHALL still exist but SHALL be ignored, and R7 changes only by write.

Verification
REQ-030 Reset, then wr_valid=1, load=0x0004, BusWires=0x1234 -> R2=0x1234 the next cycle, all other registers 0, load_err=0.
REQ-031 wr_valid=1, load=0x0003 -> R0 and R1 unchanged, a one-cycle load_err pulse, err_count=1; 300 such writes -> err_count=255.
REQ-032 Write with load=0x1000, BusWires=0xA5A5 -> IR=0xA5A5, wr_ready=0 for one cycle, and a write held valid during STALL (load=0x0001) takes effect only on the following cycle.
REQ-033 With AUTOINC, R7=0xFFFF and pc_incr=1 -> R7=0x0000; a simultaneous write of 0x0042 to R7 with pc_incr=1 -> R7=0x0042.
REQ-034 Resetn pulsed low mid-cycle while in STALL -> all outputs 0 and wr_ready=1 before the next clock edge.
REQ-035 wr_valid=0 with load=0x1FFF -> no register change, no error, state stays IDLE.
